// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for the memory stage: lane-steered stores, asynchronous word reads,
// zero-fill sweep after reset or on request, and sticky capture of faulting stores.
`ifndef RISCV_BIG_ENDIAN
`define RISCV_BIG_ENDIAN 1
`endif
`ifndef RISCV_LITTLE_ENDIAN
`define RISCV_LITTLE_ENDIAN 0
`endif

module riscv_dmem_resp #(
    parameter int unsigned MP_DATA_WIDTH     = 32,
    parameter int unsigned MP_ADDR_WIDTH     = 32,
    parameter int unsigned MP_MEM_ADDR_WIDTH = 10,
    parameter int unsigned MP_ENDIANESS      = `RISCV_BIG_ENDIAN
) (
    input  logic                     iclk,
    input  logic                     irst_n,
    input  logic [MP_ADDR_WIDTH-1:0] iaddr,
    input  logic                     iwr_en,
    input  logic [MP_DATA_WIDTH-1:0] iwr_data,
    input  logic [1:0]               iwr_be,
    input  logic                     iclr_start,
    input  logic                     ierr_clr,
    output logic [MP_DATA_WIDTH-1:0] ord_data,
    output logic                     obusy,
    output logic                     omisalign,
    output logic [MP_ADDR_WIDTH-1:0] ofault_addr,
    output logic [15:0]              ostore_cnt
);

    localparam int unsigned Depth     = 2 ** MP_MEM_ADDR_WIDTH;
    localparam bit          BigEndian = (MP_ENDIANESS == `RISCV_BIG_ENDIAN);

    localparam logic [MP_MEM_ADDR_WIDTH-1:0] CntOne  = 1;
    localparam logic [MP_MEM_ADDR_WIDTH-1:0] CntLast = '1;

    typedef enum logic {
        StClear,
        StReady
    } state_e;

    state_e                       state_q, state_d;
    logic [MP_MEM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                         misalign_q, misalign_d;
    logic [MP_ADDR_WIDTH-1:0]     fault_addr_q, fault_addr_d;
    logic [15:0]                  store_cnt_q, store_cnt_d;

    logic [MP_DATA_WIDTH-1:0]     mem_q [Depth];

    logic [MP_MEM_ADDR_WIDTH-1:0] word_idx;
    logic [MP_DATA_WIDTH-1:0]     rd_word;
    logic                         busy;

    logic [3:0]                   wr_mask;
    logic [MP_DATA_WIDTH-1:0]     wr_word;
    logic [MP_DATA_WIDTH-1:0]     merged_word;
    logic [1:0]                   byte_pos;
    logic                         half_hi;
    logic                         size_fault;
    logic                         store_req;
    logic                         store_fault;
    logic                         store_commit;

    logic                         mem_we;
    logic [MP_MEM_ADDR_WIDTH-1:0] mem_idx;
    logic [MP_DATA_WIDTH-1:0]     mem_wdata;

    // Address bits above the RAM index alias; they are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^iaddr[MP_ADDR_WIDTH-1:MP_MEM_ADDR_WIDTH+2];

    assign word_idx = iaddr[MP_MEM_ADDR_WIDTH+1:2];
    assign rd_word  = mem_q[word_idx];
    assign busy     = (state_q == StClear);

    // Big endian places byte offset k in lane 3-k, i.e. the bitwise inverse of k.
    assign byte_pos = BigEndian ? ~iaddr[1:0] : iaddr[1:0];
    assign half_hi  = BigEndian ? ~iaddr[1] : iaddr[1];

    always_comb begin
        wr_mask    = 4'b0000;
        wr_word    = '0;
        size_fault = 1'b0;
        unique case (iwr_be)
            2'b00: begin
                wr_word           = {4{iwr_data[7:0]}};
                wr_mask[byte_pos] = 1'b1;
            end
            2'b01: begin
                wr_word    = {2{iwr_data[15:0]}};
                wr_mask    = half_hi ? 4'b1100 : 4'b0011;
                size_fault = iaddr[0];
            end
            2'b10: begin
                wr_word    = iwr_data;
                wr_mask    = 4'b1111;
                size_fault = (iaddr[1:0] != 2'b00);
            end
            2'b11: begin
                size_fault = 1'b1;
            end
        endcase
    end

    always_comb begin
        merged_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) begin
                merged_word[8*i +: 8] = wr_word[8*i +: 8];
            end
        end
    end

    assign store_req    = iwr_en && !busy;
    assign store_fault  = store_req && size_fault;
    assign store_commit = store_req && !size_fault;

    // Sweep FSM and RAM write-port steering.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_idx   = word_idx;
        mem_wdata = merged_word;
        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_idx   = cnt_q;
                mem_wdata = '0;
                if (iclr_start) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StReady: begin
                mem_we = store_commit;
                if (iclr_start) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
        endcase
        // Reset takes priority: nothing reaches the RAM while irst_n is low.
        if (!irst_n) begin
            mem_we = 1'b0;
        end
    end

    always_comb begin
        misalign_d   = misalign_q;
        fault_addr_d = fault_addr_q;
        store_cnt_d  = store_cnt_q;
        if (ierr_clr) begin
            misalign_d   = 1'b0;
            fault_addr_d = '0;
        end
        // A fault coinciding with a clear wins and captures the new address.
        if (store_fault) begin
            misalign_d = 1'b1;
            if (!misalign_q || ierr_clr) begin
                fault_addr_d = iaddr;
            end
        end
        if (store_commit) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state_q      <= StClear;
            cnt_q        <= '0;
            misalign_q   <= 1'b0;
            fault_addr_q <= '0;
            store_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            misalign_q   <= misalign_d;
            fault_addr_q <= fault_addr_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    always_ff @(posedge iclk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

    assign ord_data    = busy ? '0 : rd_word;
    assign obusy       = busy;
    assign omisalign   = misalign_q;
    assign ofault_addr = fault_addr_q;
    assign ostore_cnt  = store_cnt_q;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Bench for riscv_dmem_resp: little- and big-endian instances share stimulus and are checked
// against a byte-level reference model.
`ifndef RISCV_BIG_ENDIAN
`define RISCV_BIG_ENDIAN 1
`endif
`ifndef RISCV_LITTLE_ENDIAN
`define RISCV_LITTLE_ENDIAN 0
`endif

module tb_riscv_dmem_resp;

    localparam int unsigned MemAw = 4;
    localparam int unsigned Depth = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iaddr;
    logic        iwr_en;
    logic [31:0] iwr_data;
    logic [1:0]  iwr_be;
    logic        iclr_start;
    logic        ierr_clr;

    logic [31:0] rd_le, rd_be, faddr_le, faddr_be;
    logic        busy_le, busy_be, mis_le, mis_be;
    logic [15:0] cnt_le, cnt_be;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state
    logic [31:0] mle [Depth];
    logic [31:0] mbe [Depth];
    logic        mmis;
    logic [31:0] maddr;
    logic [15:0] mcnt;
    int          mbusy;
    bit          mvalid = 1'b0;

    always #5 clk = ~clk;

    riscv_dmem_resp #(
        .MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32), .MP_MEM_ADDR_WIDTH(MemAw),
        .MP_ENDIANESS(`RISCV_LITTLE_ENDIAN)
    ) u_le (
        .iclk(clk), .irst_n(rst_n), .iaddr(iaddr), .iwr_en(iwr_en), .iwr_data(iwr_data),
        .iwr_be(iwr_be), .iclr_start(iclr_start), .ierr_clr(ierr_clr), .ord_data(rd_le),
        .obusy(busy_le), .omisalign(mis_le), .ofault_addr(faddr_le), .ostore_cnt(cnt_le)
    );

    riscv_dmem_resp #(
        .MP_DATA_WIDTH(32), .MP_ADDR_WIDTH(32), .MP_MEM_ADDR_WIDTH(MemAw),
        .MP_ENDIANESS(`RISCV_BIG_ENDIAN)
    ) u_be (
        .iclk(clk), .irst_n(rst_n), .iaddr(iaddr), .iwr_en(iwr_en), .iwr_data(iwr_data),
        .iwr_be(iwr_be), .iclr_start(iclr_start), .ierr_clr(ierr_clr), .ord_data(rd_be),
        .obusy(busy_be), .omisalign(mis_be), .ofault_addr(faddr_be), .ostore_cnt(cnt_be)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp)
        else begin
            nfail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Byte at offset k of a word, placed by the endian rule.
    function automatic logic [31:0] put_byte(input logic [31:0] w, input int k,
                                             input logic [7:0] b, input bit big);
        int pos;
        pos = big ? 3 - k : k;
        w[pos*8 +: 8] = b;
        return w;
    endfunction

    function automatic logic [31:0] apply_store(input logic [31:0] w, input logic [31:0] a,
                                                input logic [31:0] d, input logic [1:0] sz,
                                                input bit big);
        int k;
        k = int'(a[1:0]);
        case (sz)
            2'b00: w = put_byte(w, k, d[7:0], big);
            2'b01: begin
                // Lower address gets the low byte (LE) or the high byte (BE).
                w = put_byte(w, k, big ? d[15:8] : d[7:0], big);
                w = put_byte(w, k + 1, big ? d[7:0] : d[15:8], big);
            end
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic bit is_fault(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    task automatic model_edge();
        bit busy_pre;
        int wi;
        busy_pre = (mbusy > 0);
        wi       = int'(iaddr[5:2]);
        if (!rst_n) begin
            mvalid = 1'b1;
            mmis   = 1'b0;
            maddr  = '0;
            mcnt   = '0;
            mbusy  = Depth;
            for (int i = 0; i < Depth; i++) begin mle[i] = '0; mbe[i] = '0; end
        end else begin
            if (ierr_clr) begin mmis = 1'b0; maddr = '0; end
            if (iwr_en && !busy_pre) begin
                if (is_fault(iaddr, iwr_be)) begin
                    if (!mmis) maddr = iaddr;
                    mmis = 1'b1;
                end else begin
                    mle[wi] = apply_store(mle[wi], iaddr, iwr_data, iwr_be, 1'b0);
                    mbe[wi] = apply_store(mbe[wi], iaddr, iwr_data, iwr_be, 1'b1);
                    mcnt    = mcnt + 16'd1;
                end
            end
            if (iclr_start) begin
                mbusy = Depth;
                for (int i = 0; i < Depth; i++) begin mle[i] = '0; mbe[i] = '0; end
            end else if (mbusy > 0) begin
                mbusy--;
            end
        end
    endtask

    task automatic step();
        int wi;
        #1;
        wi = int'(iaddr[5:2]);
        if (mvalid && rst_n) begin
            chk("rd_pre_le", rd_le, (mbusy > 0) ? 32'h0 : mle[wi]);
            chk("rd_pre_be", rd_be, (mbusy > 0) ? 32'h0 : mbe[wi]);
        end
        @(posedge clk);
        model_edge();
        #1;
        if (mvalid) begin
            chk("busy_le", {31'b0, busy_le}, {31'b0, mbusy > 0});
            chk("busy_be", {31'b0, busy_be}, {31'b0, mbusy > 0});
            chk("rd_le", rd_le, (mbusy > 0) ? 32'h0 : mle[wi]);
            chk("rd_be", rd_be, (mbusy > 0) ? 32'h0 : mbe[wi]);
            chk("mis_le", {31'b0, mis_le}, {31'b0, mmis});
            chk("mis_be", {31'b0, mis_be}, {31'b0, mmis});
            chk("faddr_le", faddr_le, maddr);
            chk("faddr_be", faddr_be, maddr);
            chk("cnt_le", {16'b0, cnt_le}, {16'b0, mcnt});
            chk("cnt_be", {16'b0, cnt_be}, {16'b0, mcnt});
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        iaddr = a; iwr_data = d; iwr_be = sz; iwr_en = 1'b1;
        step();
        iwr_en = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a);
        iaddr = a; iwr_en = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; iaddr = '0; iwr_en = 1'b0; iwr_data = '0; iwr_be = 2'b10;
        iclr_start = 1'b0; ierr_clr = 1'b0;

        // Reset and initial sweep
        step(); step();
        rst_n = 1'b1;
        n = 0;
        while (busy_le === 1'b1 && n < 100) begin step(); n++; end
        chk("busy_len_reset", n, 16);
        for (int i = 0; i < Depth; i++) begin
            peek(i * 4);
            chk("zero_le", rd_le, 32'h0);
            chk("zero_be", rd_be, 32'h0);
        end
        chk("cnt_after_reset", {16'b0, cnt_le}, 32'h0);

        // Lane steering
        store(32'h4, 32'h11223344, 2'b10);
        store(32'h5, 32'h000000AB, 2'b00);
        peek(32'h4);
        chk("le_byte", rd_le, 32'h1122AB44);
        chk("be_byte", rd_be, 32'h11AB3344);
        chk("cnt_two", {16'b0, cnt_le}, 32'd2);
        store(32'h6, 32'h0000BEEF, 2'b01);
        peek(32'h4);
        chk("be_half", rd_be, 32'h11ABBEEF);
        chk("le_half", rd_le, 32'hBEEFAB44);

        // Misaligned stores
        store(32'h3, 32'h00005555, 2'b01);
        store(32'h8, 32'hCAFEF00D, 2'b10);
        store(32'h9, 32'h12345678, 2'b10);
        peek(32'h0);
        chk("no_wr_3_le", rd_le, 32'h0);
        chk("no_wr_3_be", rd_be, 32'h0);
        peek(32'h8);
        chk("word8_le", rd_le, 32'hCAFEF00D);
        chk("word8_be", rd_be, 32'hCAFEF00D);
        chk("mis_set", {31'b0, mis_le}, 32'd1);
        chk("faddr_first", faddr_le, 32'h3);
        chk("cnt_four", {16'b0, cnt_le}, 32'd4);

        // Fault beats a same-cycle clear, then a lone clear
        iaddr = 32'h10; iwr_be = 2'b11; iwr_en = 1'b1; ierr_clr = 1'b1;
        step();
        iwr_en = 1'b0; ierr_clr = 1'b0;
        chk("clr_fault_mis", {31'b0, mis_le}, 32'd1);
        chk("clr_fault_addr", faddr_le, 32'h10);
        ierr_clr = 1'b1;
        step();
        ierr_clr = 1'b0;
        chk("clr_mis", {31'b0, mis_be}, 32'd0);
        chk("clr_addr", faddr_be, 32'h0);

        // Requested sweep with a dropped store
        store(32'h0, 32'hDEADBEEF, 2'b10);
        peek(32'h0);
        chk("deadbeef", rd_le, 32'hDEADBEEF);
        iclr_start = 1'b1;
        step();
        iclr_start = 1'b0;
        n = 0;
        store(32'h0, 32'h00000001, 2'b10);
        n++;
        iaddr = 32'h0;
        while (busy_be === 1'b1 && n < 100) begin step(); n++; end
        chk("busy_len_clr", n, 16);
        peek(32'h0);
        chk("swept_le", rd_le, 32'h0);
        chk("swept_be", rd_be, 32'h0);
        chk("cnt_five", {16'b0, cnt_le}, 32'd5);

        // Reset mid-sweep restarts the full sweep
        iclr_start = 1'b1;
        step();
        iclr_start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n = 0;
        while (busy_le === 1'b1 && n < 100) begin step(); n++; end
        chk("busy_len_midrst", n, 16);
        chk("cnt_midrst", {16'b0, cnt_be}, 32'd0);

        // Randomised traffic, including aliased upper address bits
        repeat (400) begin
            iaddr    = $urandom;
            iwr_be   = 2'($urandom_range(3, 0));
            if ($urandom_range(1, 0) == 1) begin
                if (iwr_be == 2'b10) iaddr[1:0] = 2'b00;
                if (iwr_be == 2'b01) iaddr[0] = 1'b0;
            end
            iwr_data   = $urandom;
            iwr_en     = ($urandom_range(3, 0) != 0);
            ierr_clr   = ($urandom_range(9, 0) == 0);
            iclr_start = ($urandom_range(99, 0) == 0);
            step();
        end
        iwr_en = 1'b0; ierr_clr = 1'b0; iclr_start = 1'b0;
        n = 0;
        while (busy_le === 1'b1 && n < 100) begin step(); n++; end
        for (int i = 0; i < Depth; i++) peek(i * 4);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
